// File: rtl/pulse_stretcher.sv
// Stretches single-cycle ticks into a HIGH_CYCLES-wide level pulse followed by a
// LOW_CYCLES guard gap. Define PULSE_STRETCH_RETRIGGER_EN to let ticks in HIGH extend the pulse.
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  output logic level,
  output logic busy,
  output logic dropped
);

  localparam int MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HIGH = 2'b01,
    S_GAP  = 2'b10
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dropped_q;

  // NOTE: state is updated with non-blocking assignments so every branch below
  // reads the pre-edge value of state_q and cnt_q, exactly like the hardware flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            state_q <= S_HIGH;
            cnt_q   <= HIGH_LOAD;
          end
        end
        S_HIGH: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
          if (tick) begin
            cnt_q <= HIGH_LOAD;
          end else if (cnt_q == '0) begin
            state_q <= S_GAP;
            cnt_q   <= LOW_LOAD;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
`else
          dropped_q <= tick;
          if (cnt_q == '0) begin
            state_q <= S_GAP;
            cnt_q   <= LOW_LOAD;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
`endif
        end
        S_GAP: begin
          // A tick here never shortens the gap, even on the GAP->IDLE edge.
          dropped_q <= tick;
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Outputs decode the state flop only, so they cannot glitch on tick.
  assign level   = (state_q == S_HIGH);
  assign busy    = (state_q != S_IDLE);
  assign dropped = dropped_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: interval-based reference model checked every cycle on two
// instances (4/2 and 1/1), plus directed scenarios with literal expectations.
module tb_pulse_stretcher;

`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic level0, busy0, drop0;
  logic level1, busy1, drop1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pulse_stretcher #(.HIGH_CYCLES(4), .LOW_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset), .tick(tick),
    .level(level0), .busy(busy0), .dropped(drop0)
  );

  pulse_stretcher #(.HIGH_CYCLES(1), .LOW_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .tick(tick),
    .level(level1), .busy(busy1), .dropped(drop1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remembers the accept edge and the last edge after which level is high;
  // the phase after any edge c follows from where c falls in those intervals.
  int  mh [2] = '{4, 1};
  int  ml [2] = '{2, 1};
  bit  have [2] = '{1'b0, 1'b0};
  int  acc  [2] = '{0, 0};
  int  hlast[2] = '{0, 0};
  bit  m_level[2] = '{1'b0, 1'b0};
  bit  m_busy [2] = '{1'b0, 1'b0};
  bit  m_drop [2] = '{1'b0, 1'b0};
  int  e = 0;

  // 0 = idle, 1 = high, 2 = gap, for the cycle following edge c
  function automatic int phase(bit hv, int a, int hl, int lw, int c);
    if (!hv || c < a) return 0;
    if (c <= hl)      return 1;
    if (c <= hl + lw) return 2;
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e <= 0;
      for (int k = 0; k < 2; k++) begin
        have[k]    <= 1'b0;
        m_level[k] <= 1'b0;
        m_busy[k]  <= 1'b0;
        m_drop[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        automatic bit hv   = have[k];
        automatic int aa   = acc[k];
        automatic int hh   = hlast[k];
        automatic int prev = phase(hv, aa, hh, ml[k], e - 1);
        automatic bit drp  = 1'b0;
        automatic int cur;
        if (tick) begin
          if (prev == 0) begin
            hv = 1'b1;
            aa = e;
            hh = e + mh[k] - 1;
          end else if (RETRIG && prev == 1) begin
            hh = e + mh[k] - 1;
          end else begin
            drp = 1'b1;
          end
        end
        cur = phase(hv, aa, hh, ml[k], e);
        have[k]    <= hv;
        acc[k]     <= aa;
        hlast[k]   <= hh;
        m_drop[k]  <= drp;
        m_level[k] <= (cur == 1);
        m_busy[k]  <= (cur != 0);
      end
      e <= e + 1;
    end
  end

  // History indexed by cycle number (cycle k follows edge k-1)
  logic h_lvl [64];
  logic h_busy[64];
  logic h_drop[64];
  logic s_lvl [64];

  always @(negedge clk) begin
    check("m0_level",   32'(level0), 32'(m_level[0]));
    check("m0_busy",    32'(busy0),  32'(m_busy[0]));
    check("m0_dropped", 32'(drop0),  32'(m_drop[0]));
    check("m1_level",   32'(level1), 32'(m_level[1]));
    check("m1_busy",    32'(busy1),  32'(m_busy[1]));
    check("m1_dropped", 32'(drop1),  32'(m_drop[1]));
    if (e < 64) begin
      h_lvl[e]  = level0;
      h_busy[e] = busy0;
      h_drop[e] = drop0;
      s_lvl[e]  = level1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_e(input int n);
    int guard;
    guard = 0;
    while (e != n && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (e != n) check("wait_timeout", 32'(e), 32'(n));
  endtask

  logic [20:0] pat_main;
  logic [8:0]  pat_small;
  logic [6:0]  pat_drop;

  initial begin
    // Reset held 3 cycles with tick high: outputs stay low throughout
    tick = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_level",   32'(level0), 32'd0);
      check("rst_busy",    32'(busy0),  32'd0);
      check("rst_dropped", 32'(drop0),  32'd0);
    end
    reset = 1'b0;

    // tick held for edges 0..20
    repeat (21) @(negedge clk);
    tick = 1'b0;
    pat_main  = 21'b111100011110001111000;
    pat_small = 9'b100100100;
    pat_drop  = 7'b0111111;
    for (int c = 1; c <= 21; c++)
      check($sformatf("sustain_level_c%0d", c), 32'(h_lvl[c]), 32'(pat_main[21-c]));
    for (int c = 1; c <= 9; c++)
      check($sformatf("small_level_c%0d", c), 32'(s_lvl[c]), 32'(pat_small[9-c]));
    if (!RETRIG)
      for (int c = 1; c <= 7; c++)
        check($sformatf("sustain_drop_c%0d", c), 32'(h_drop[c]), 32'(pat_drop[7-c]));

    // Single tick at edge 10
    do_reset();
    wait_e(10);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_e(20);
    for (int c = 11; c <= 14; c++) check($sformatf("single_level_c%0d", c), 32'(h_lvl[c]), 32'd1);
    check("single_level_c15", 32'(h_lvl[15]), 32'd0);
    check("single_level_c16", 32'(h_lvl[16]), 32'd0);
    check("single_busy_c15",  32'(h_busy[15]), 32'd1);
    check("single_busy_c16",  32'(h_busy[16]), 32'd1);
    check("single_busy_c17",  32'(h_busy[17]), 32'd0);
    for (int c = 11; c <= 19; c++) check($sformatf("single_drop_c%0d", c), 32'(h_drop[c]), 32'd0);

    // Ticks at edges 10 and 12
    do_reset();
    wait_e(10);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_e(22);
    if (RETRIG) begin
      for (int c = 11; c <= 16; c++) check($sformatf("retrig_level_c%0d", c), 32'(h_lvl[c]), 32'd1);
      check("retrig_level_c17", 32'(h_lvl[17]), 32'd0);
      for (int c = 11; c <= 20; c++) check($sformatf("retrig_drop_c%0d", c), 32'(h_drop[c]), 32'd0);
    end else begin
      for (int c = 11; c <= 14; c++) check($sformatf("double_level_c%0d", c), 32'(h_lvl[c]), 32'd1);
      check("double_level_c15", 32'(h_lvl[15]), 32'd0);
      check("double_level_c16", 32'(h_lvl[16]), 32'd0);
      for (int c = 11; c <= 20; c++)
        check($sformatf("double_drop_c%0d", c), 32'(h_drop[c]), (c == 13) ? 32'd1 : 32'd0);
    end

    // Async reset mid-HIGH, between edges
    do_reset();
    wait_e(10);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_e(12);
    check("async_pre_level", 32'(level0), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_level", 32'(level0), 32'd0);
    check("async_busy",  32'(busy0),  32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_busy",  32'(busy0),  32'd0);
      check("post_rst_level", 32'(level0), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
